// File: rtl/mm_pkg.sv
// Shared constants, state encoding and width helpers for the modular-multiply datapath.
package mm_pkg;

    localparam int unsigned RADIX      = 78;
    localparam int unsigned SIZE       = 3072;
    localparam int unsigned B_W        = SIZE + 2;
    localparam int unsigned DIGITS     = 40;
    localparam int unsigned IE_LATENCY = 4;
    localparam int unsigned TIMEOUT    = 15;

    function automatic int unsigned idx_width(input int unsigned n);
        return $clog2(n);
    endfunction

    localparam int unsigned IDX_W = idx_width(DIGITS);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HAND,
        S_GAP,
        S_FIN
    } state_t;

endpackage

// File: rtl/digit_shifter_78.sv
// Operand B register: parallel load, right shift by one digit, low digit exposed.
module digit_shifter_78
    import mm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [B_W-1:0]   d,
    output logic [RADIX-1:0] digit_c
);

    logic [B_W-1:0] q;

    // Zeros shift in from the top, so the final partial digit is zero-extended.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= q >> RADIX;
        end
    end

    assign digit_c = q[RADIX-1:0];

endmodule

// File: rtl/outer_loop_ctrl_78.sv
// Outer-loop sequencer: issues each B digit to the inner loop, waits for completion,
// and hands every pass result to the accumulator over valid/ready.
module outer_loop_ctrl_78
    import mm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [B_W-1:0]   b,
    output logic             ie_en,
    output logic [RADIX-1:0] ie_bi,
    input  logic             ie_done,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             acc_last,
    output logic [IDX_W-1:0] digit_idx,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_n;
    logic [IDX_W-1:0] idx_n;
    logic             load;
    logic             shift;
    logic             set_err;
    logic             is_last;
    logic [RADIX-1:0] low_digit;

    digit_shifter_78 u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .shift   (shift),
        .d       (b),
        .digit_c (low_digit)
    );

    // Next state, counters and register strobes.
    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        idx_n      = digit_idx;
        load       = 1'b0;
        shift      = 1'b0;
        set_err    = 1'b0;
        is_last    = (digit_idx == IDX_W'(DIGITS - 1));
        case (state)
            S_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    idx_n   = '0;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wait_cnt_n = '0;
                state_n    = S_WAIT;
            end
            S_WAIT: begin
                if (ie_done) begin
                    state_n = S_HAND;
                end else begin
                    wait_cnt_n = wait_cnt + CNT_W'(1);
                    if (wait_cnt_n == CNT_W'(TIMEOUT)) begin
                        set_err = 1'b1;
                        state_n = S_IDLE;
                    end
                end
            end
            S_HAND: begin
                if (acc_ready) begin
                    if (is_last) begin
                        state_n = S_FIN;
                    end else begin
                        shift   = 1'b1;
                        idx_n   = digit_idx + IDX_W'(1);
                        state_n = S_GAP;
                    end
                end
            end
            S_GAP:   state_n = S_ISSUE;
            S_FIN:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // State register; outputs are registered from the next-state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            digit_idx <= '0;
            ie_en     <= 1'b0;
            ie_bi     <= '0;
            acc_valid <= 1'b0;
            acc_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            wait_cnt  <= wait_cnt_n;
            digit_idx <= idx_n;
            ie_en     <= (state_n == S_ISSUE);
            // The shifter loads on the same edge as the first issue, so take digit 0 from b.
            if (state_n == S_ISSUE) begin
                ie_bi <= load ? b[RADIX-1:0] : low_digit;
            end
            acc_valid <= (state_n == S_HAND);
            acc_last  <= (state_n == S_HAND) && (idx_n == IDX_W'(DIGITS - 1));
            busy      <= (state_n != S_IDLE);
            done      <= (state_n == S_FIN);
            if (set_err) begin
                err <= 1'b1;
            end else if (load) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_outer_loop_ctrl_78.sv
// Directed bench for outer_loop_ctrl_78 with a fixed-latency inner-loop model.
`timescale 1ns/1ps
module tb_outer_loop_ctrl_78;
    import mm_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [B_W-1:0]   b;
    logic             ie_en;
    logic [RADIX-1:0] ie_bi;
    logic             ie_done;
    logic             acc_valid;
    logic             acc_ready;
    logic             acc_last;
    logic [IDX_W-1:0] digit_idx;
    logic             busy;
    logic             done;
    logic             err;

    outer_loop_ctrl_78 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .b         (b),
        .ie_en     (ie_en),
        .ie_bi     (ie_bi),
        .ie_done   (ie_done),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .acc_last  (acc_last),
        .digit_idx (digit_idx),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    int               issue_cyc [DIGITS];
    logic [RADIX-1:0] issue_bi  [DIGITS];
    int n_issue, n_last, last_idx, n_done, done_cyc, err_cyc;
    int first_err, bp_bad, busy_after, busy_at_err, rst_zero;

    logic [B_W-1:0]   pat;
    logic [B_W-1:0]   alt;
    logic [RADIX-1:0] ones78;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Gaps between consecutive ie_en pulses; one gap may be stretched by backpressure.
    function automatic int gap_errs(input int slow_digit, input int slow_gap);
        int bad = 0;
        for (int i = 0; i + 1 < DIGITS; i++) begin
            if (issue_cyc[i+1] - issue_cyc[i] != ((i == slow_digit) ? slow_gap : 7)) bad++;
        end
        return bad;
    endfunction

    // Digit k of the pattern operand is k+1.
    function automatic int pat_errs();
        int bad = 0;
        for (int k = 0; k < DIGITS; k++) begin
            if (issue_bi[k] != RADIX'(k + 1)) bad++;
        end
        return bad;
    endfunction

    // mode: 0 normal, 1 backpressure on digit 2, 2 no ie_done on digit 7,
    //       3 reset during WAIT of digit 10, 4 start pulse with alt operand on digit 5
    task automatic run_op(input logic [B_W-1:0] bv, input logic [B_W-1:0] bv_alt, input int mode);
        int done_at, bp_left, bp_on;
        n_issue = 0; n_last = 0; last_idx = -1; n_done = 0; done_cyc = -1; err_cyc = -1;
        first_err = -1; bp_bad = 0; busy_after = -1; busy_at_err = -1; rst_zero = 0;
        done_at = -1; bp_left = -1; bp_on = 0;
        for (int i = 0; i < DIGITS; i++) begin
            issue_cyc[i] = -1;
            issue_bi[i]  = '1;
        end
        b = bv; start = 1'b1; ie_done = 1'b1; acc_ready = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (k == 0) first_err = int'(err);
            if (ie_en) begin
                if (n_issue < DIGITS) begin
                    issue_cyc[n_issue] = k;
                    issue_bi[n_issue]  = ie_bi;
                end
                n_issue++;
                if (!(mode == 2 && digit_idx == 6'd7)) done_at = k + IE_LATENCY;
                if (mode == 4 && digit_idx == 6'd5) begin
                    start = 1'b1;
                    b     = bv_alt;
                end
            end
            ie_done = (k == done_at);
            if (mode == 1 && acc_valid && digit_idx == 6'd2 && bp_on == 0) begin
                bp_on   = 1;
                bp_left = 5;
            end
            if (bp_on == 1 && bp_left >= 0) begin
                if (!acc_valid || digit_idx != 6'd2 || ie_bi != issue_bi[2]) bp_bad++;
                acc_ready = (bp_left == 0);
                bp_left--;
            end else begin
                acc_ready = 1'b1;
            end
            if (acc_valid && acc_ready && acc_last) begin
                n_last++;
                last_idx = int'(digit_idx);
            end
            if (mode == 3 && n_issue == 11 && k == issue_cyc[10] + 2) begin
                rst = 1'b1; ie_done = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                rst_zero = ({ie_en, acc_valid, acc_last, busy, done, err} == 6'b0 &&
                            ie_bi == '0 && digit_idx == '0) ? 1 : 0;
                break;
            end
            if (done) begin
                n_done++;
                done_cyc = k;
                ie_done = 1'b0;
                @(posedge clk); #1;
                busy_after = int'(busy);
                break;
            end
            if (err) begin
                err_cyc     = k;
                busy_at_err = int'(busy);
                break;
            end
        end
        start = 1'b0; ie_done = 1'b0; acc_ready = 1'b1;
    endtask

    initial begin
        logic [DIGITS*RADIX-1:0] wide;
        rst = 1'b1; start = 1'b0; ie_done = 1'b0; acc_ready = 1'b1; b = '0;
        ones78 = '1;
        wide = '0;
        for (int k = 0; k < DIGITS; k++) wide[k*RADIX +: RADIX] = RADIX'(k + 1);
        pat = wide[B_W-1:0];
        alt = ~pat;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ctl", {ie_en, acc_valid, acc_last, busy, done, err}, 6'b0);
        check_eq("rst_ie_bi", ie_bi, 0);
        check_eq("rst_digit_idx", digit_idx, 0);
        rst = 1'b0;

        // All-ones operand, ready tied high
        run_op('1, '0, 0);
        check_eq("basic_n_issue", n_issue, 40);
        check_eq("basic_first_issue", issue_cyc[0], 0);
        check_eq("basic_spacing", gap_errs(-1, 7), 0);
        check_eq("basic_bi0", issue_bi[0], ones78);
        check_eq("basic_bi38", issue_bi[38], ones78);
        check_eq("basic_bi39", issue_bi[39], 78'hFFFF_FFFF);
        check_eq("basic_n_last", n_last, 1);
        check_eq("basic_last_idx", last_idx, 39);
        check_eq("basic_done_cyc", done_cyc - issue_cyc[0], 279);
        check_eq("basic_busy_after", busy_after, 0);
        check_eq("basic_err", err, 0);

        // Backpressure on digit 2
        run_op(pat, '0, 1);
        check_eq("bp_n_issue", n_issue, 40);
        check_eq("bp_spacing", gap_errs(2, 12), 0);
        check_eq("bp_hold", bp_bad, 0);
        check_eq("bp_done_cyc", done_cyc - issue_cyc[0], 284);

        // Inner loop stalls on digit 7
        run_op(pat, '0, 2);
        check_eq("to_n_issue", n_issue, 8);
        check_eq("to_err_cyc", err_cyc - issue_cyc[7], 16);
        check_eq("to_no_done", n_done, 0);
        check_eq("to_idle", busy_at_err, 0);

        // Restart clears err; every digit of the pattern appears in order
        run_op(pat, '0, 0);
        check_eq("rs_err_cleared", first_err, 0);
        check_eq("ext_n_issue", n_issue, 40);
        check_eq("ext_digits", pat_errs(), 0);
        check_eq("ext_done", n_done, 1);

        // Reset while waiting on digit 10
        run_op(pat, '0, 3);
        check_eq("mr_outputs_zero", rst_zero, 1);
        check_eq("mr_no_done", n_done, 0);
        run_op(B_W'(1), '0, 0);
        check_eq("mr_bi0", issue_bi[0], 1);
        begin
            int nz = 0;
            for (int k = 1; k < DIGITS; k++) if (issue_bi[k] != '0) nz++;
            check_eq("mr_bi_rest", nz, 0);
        end
        check_eq("mr_done", n_done, 1);

        // Start while busy is ignored
        run_op(pat, alt, 4);
        check_eq("sb_n_issue", n_issue, 40);
        check_eq("sb_digits", pat_errs(), 0);
        check_eq("sb_done", n_done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
